memset_stream_ctrl: RTL and testbench
=====================================

# memset_stream_ctrl

Sequencer for the accelerator's memset fill stream. A start pulse latches a fill byte and a byte length from CSRs. The block then emits exactly ceil(length / bytes-per-beat) beats of the replicated fill byte on a valid/ready output stream. The last beat carries a partial byte strobe. It sits between the CSR manager and the streamer write port, and it owns the busy/done status the CSR manager reports.

## Interface
Parameters:
- dataWidth, 512, output beat width in bits; must be a multiple of 8 with dataWidth/8 a power of two (B = dataWidth/8 bytes per beat)
- lenWidth, 32, width of the byte-length CSR and of the internal counters

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- csr_value_i  input  32  fill value; only bits [7:0] used
- csr_len_i  input  lenWidth  transfer length in bytes
- csr_start_i  input  1  start pulse; sampled only in IDLE
- csr_abort_i  input  1  request early termination; level, sampled every cycle in RUN
- data_o_valid  output  1  beat valid
- data_o_ready  input  1  downstream ready
- data_o_bits  output  dataWidth  fill byte replicated B times
- data_o_strb  output  dataWidth/8  byte enables, bit i covers bits [8i+7:8i]
- data_o_last  output  1  high on the final beat of a transfer
- busy_o  output  1  high in RUN and DONE
- done_o  output  1  one-cycle completion pulse
- beats_sent_o  output  lenWidth  beats accepted in the current or most recent transfer

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On csr_start_i, latch fill = csr_value_i[7:0].
  - Compute beats = ceil(csr_len_i / B) and tail = csr_len_i mod B.
  - Clear beats_sent_o.
  - If csr_len_i == 0, go to DONE without emitting any beat. Otherwise load remaining = beats and go to RUN.
- RUN:
  - data_o_valid = 1 continuously.
  - A handshake is data_o_valid & data_o_ready. On each handshake: remaining -= 1, beats_sent_o += 1.
  - data_o_last = (remaining == 1) | abort_pending.
  - A handshake while data_o_last = 1 moves to DONE.
- Strobe:
  - All ones on every beat except the last.
  - On the last beat, strobe = low `tail` bits set, or all ones if tail == 0.
  - On an aborted last beat, strobe is all ones.
- Abort:
  - csr_abort_i high in RUN sets abort_pending.
  - Valid is never retracted. The beat currently presented, or the next one, is the final beat and carries last = 1.
  - abort_pending clears on entry to IDLE.
- DONE: done_o = 1 for exactly this cycle, then go to IDLE.
- csr_start_i outside IDLE is ignored. It does not queue.
- data_o_bits is always the latched fill byte replicated, including while valid = 0.
- beats computation: (csr_len_i + B - 1) >> log2(B), evaluated at lenWidth+1 bits so csr_len_i = 2^lenWidth - 1 does not overflow.

## Timing
- Reset values:
  - state IDLE, fill 0, remaining 0, abort_pending 0.
  - data_o_valid 0, data_o_last 0, data_o_strb all ones, data_o_bits 0.
  - busy_o 0, done_o 0, beats_sent_o 0.
- Start latency: start sampled in cycle t; data_o_valid and busy_o are high in cycle t+1.
- Throughput: one beat per cycle while data_o_ready = 1. Backpressure holds bits, strb and last stable.
- Completion: final handshake in cycle t gives done_o = 1 in t+1 and busy_o = 0 in t+2. A new start is accepted from t+2.
- Zero length: start in t gives busy_o and done_o high in t+1, idle in t+2, and no valid ever.
- Abort in the same cycle as a handshake on a non-last beat: the next beat is last.
- Abort on the natural last beat has no extra effect.
- rst_n asserted mid-transfer: all outputs return to reset values immediately (asynchronous). No done_o pulse is produced.

## Test plan
- B=64, len=256, value=0xA5, ready always 1: 4 consecutive beats of all-0xA5 bytes, strobe all ones, last on beat 4, done_o one cycle after, beats_sent_o=4.
- len=130: 3 beats; beat 3 strobe = 0x3 (bits 0-1 only), last=1. len=64: 1 beat, strobe all ones.
- len=0: done_o pulse in t+1, data_o_valid never high, beats_sent_o=0.
- len=512 with ready toggled randomly: 8 handshakes exactly. Bits, strb and last stable while valid & !ready. Start pulses during RUN are ignored.
- len=640, abort asserted after 3 handshakes: beat 4 has last=1, then done_o; beats_sent_o=4.
- rst_n dropped during beat 2 of len=256: valid, busy and last go 0 asynchronously with no done_o. After release, a fresh start with len=64 produces exactly 1 beat.

Source files
------------

// File: rtl/memset_stream_ctrl.sv
// memset_stream_ctrl: turns a CSR start into a stream of replicated fill-byte
// beats. The final beat carries a partial strobe, or a full strobe when the
// transfer was cut short by an abort. The block also reports busy/done status.
module memset_stream_ctrl #(
  parameter int dataWidth = 512,
  parameter int lenWidth  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              csr_value_i,
  input  logic [lenWidth-1:0]      csr_len_i,
  input  logic                     csr_start_i,
  input  logic                     csr_abort_i,
  output logic                     data_o_valid,
  input  logic                     data_o_ready,
  output logic [dataWidth-1:0]     data_o_bits,
  output logic [dataWidth/8-1:0]   data_o_strb,
  output logic                     data_o_last,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [lenWidth-1:0]      beats_sent_o
);

  localparam int B  = dataWidth / 8;
  localparam int LB = $clog2(B);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          fill_q, fill_d;
  logic [lenWidth-1:0] remaining_q, remaining_d;
  logic [lenWidth-1:0] tail_q, tail_d;
  logic                abort_q, abort_d;
  logic [lenWidth-1:0] sent_q, sent_d;

  logic [lenWidth:0]   len_ext_s;
  logic [lenWidth-1:0] beats_s;
  logic [lenWidth-1:0] tail_s;
  logic [B-1:0]        tail_mask_s;
  logic                hs_s;
  logic                value_unused_s;

  // Only the low byte of the fill value is meaningful.
  assign value_unused_s = ^csr_value_i[31:8];

  // The beat count is computed one bit wider so that a maximal length cannot
  // wrap when the rounding term is added.
  assign len_ext_s = {1'b0, csr_len_i} + (lenWidth+1)'(B - 1);
  assign beats_s   = lenWidth'(len_ext_s >> LB);
  assign tail_s    = csr_len_i & lenWidth'(B - 1);

  // All outputs are decoded from registered state only, so none of them
  // depends combinationally on an input.
  assign data_o_valid = (state_q == RUN);
  assign data_o_last  = (state_q == RUN) && ((remaining_q == lenWidth'(1)) || abort_q);
  assign data_o_bits  = {B{fill_q}};
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign beats_sent_o = sent_q;
  assign hs_s         = data_o_valid & data_o_ready;

  // Byte-enable mask covering the low `tail` bytes of a partial last beat.
  always_comb begin
    tail_mask_s = '0;
    for (int i = 0; i < B; i++) begin
      tail_mask_s[i] = (lenWidth'(i) < tail_q);
    end
  end

  // Strobe: a partial mask only on the natural last beat with a nonzero tail.
  // Every other beat is all ones, including a last beat forced by abort.
  always_comb begin
    data_o_strb = '1;
    if ((state_q == RUN) && (remaining_q == lenWidth'(1)) && (tail_q != '0)) begin
      data_o_strb = tail_mask_s;
    end else begin
      data_o_strb = '1;
    end
  end

  // Next-state logic: start latching in IDLE, beat accounting and abort in
  // RUN, one-cycle completion in DONE.
  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    remaining_d = remaining_q;
    tail_d      = tail_q;
    abort_d     = abort_q;
    sent_d      = sent_q;
    case (state_q)
      IDLE: begin
        if (csr_start_i) begin
          fill_d  = csr_value_i[7:0];
          tail_d  = tail_s;
          sent_d  = '0;
          abort_d = 1'b0;
          if (csr_len_i == '0) begin
            remaining_d = '0;
            state_d     = DONE;
          end else begin
            remaining_d = beats_s;
            state_d     = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (csr_abort_i) begin
          abort_d = 1'b1;
        end else begin
          abort_d = abort_q;
        end
        if (hs_s) begin
          remaining_d = remaining_q - lenWidth'(1);
          sent_d      = sent_q + lenWidth'(1);
          if (data_o_last) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        // Clear leftovers so IDLE always presents a clean full strobe.
        remaining_d = '0;
        abort_d     = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        remaining_d = '0;
        abort_d     = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fill_q      <= 8'h00;
      remaining_q <= '0;
      tail_q      <= '0;
      abort_q     <= 1'b0;
      sent_q      <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      remaining_q <= remaining_d;
      tail_q      <= tail_d;
      abort_q     <= abort_d;
      sent_q      <= sent_d;
    end
  end

endmodule

// File: tb/tb_memset_stream_ctrl.sv
// Table-driven bench for memset_stream_ctrl (dataWidth 512, 64 bytes/beat).
module tb_memset_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  csr_value_i = 32'h0;
  logic [31:0]  csr_len_i = 32'h0;
  logic         csr_start_i = 1'b0;
  logic         csr_abort_i = 1'b0;
  logic         data_o_valid;
  logic         data_o_ready = 1'b1;
  logic [511:0] data_o_bits;
  logic [63:0]  data_o_strb;
  logic         data_o_last;
  logic         busy_o;
  logic         done_o;
  logic [31:0]  beats_sent_o;

  int n_tests = 0;
  int n_fail  = 0;

  memset_stream_ctrl #(.dataWidth(512), .lenWidth(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_value_i(csr_value_i), .csr_len_i(csr_len_i),
    .csr_start_i(csr_start_i), .csr_abort_i(csr_abort_i),
    .data_o_valid(data_o_valid), .data_o_ready(data_o_ready),
    .data_o_bits(data_o_bits), .data_o_strb(data_o_strb),
    .data_o_last(data_o_last), .busy_o(busy_o), .done_o(done_o),
    .beats_sent_o(beats_sent_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] len;
    logic [31:0] value;
    bit          rmode;      // random ready and stray start pulses
    int          abort_at;   // abort raised together with this handshake (0 = none)
    int          beats;      // expected handshakes
    logic [63:0] last_strb;  // expected strobe on the final beat
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int           sent;
    int           cyc;
    logic         rdy;
    logic         vld;
    logic         hold;
    logic [511:0] pb;
    logic [63:0]  ps;
    logic         pl;
    logic [511:0] exp_bits;
    logic [63:0]  exp_strb;
    exp_bits = {64{v.value[7:0]}};
    @(negedge clk);
    csr_len_i    = v.len;
    csr_value_i  = v.value;
    csr_start_i  = 1'b1;
    data_o_ready = 1'b1;
    @(negedge clk);
    csr_start_i = 1'b0;
    csr_len_i   = 32'h0;
    #1;
    chk("busy_after_start", busy_o, 1'b1);
    if (v.beats == 0) begin
      chk("zero_done", done_o, 1'b1);
      chk("zero_valid", data_o_valid, 1'b0);
      chk("zero_sent", beats_sent_o, 32'd0);
      @(negedge clk);
      #1;
      chk("zero_idle_busy", busy_o, 1'b0);
      chk("zero_idle_done", done_o, 1'b0);
      chk("zero_idle_valid", data_o_valid, 1'b0);
      return;
    end
    chk("start_no_done", done_o, 1'b0);
    sent = 0;
    cyc  = 0;
    hold = 1'b0;
    pb   = '0;
    ps   = '0;
    pl   = 1'b0;
    while (sent < v.beats && cyc < 200) begin
      rdy = v.rmode ? 1'($urandom_range(0, 1)) : 1'b1;
      csr_abort_i = 1'b0;
      if (v.abort_at != 0 && sent == v.abort_at - 1) begin
        rdy = 1'b1;
        csr_abort_i = 1'b1;
      end
      data_o_ready = rdy;
      csr_start_i  = v.rmode ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      vld = data_o_valid;
      exp_strb = (sent + 1 == v.beats) ? v.last_strb : 64'hFFFF_FFFF_FFFF_FFFF;
      chk("run_valid", data_o_valid, 1'b1);
      chk("run_done", done_o, 1'b0);
      chk("run_bits", data_o_bits, exp_bits);
      chk("run_strb", data_o_strb, exp_strb);
      chk("run_last", data_o_last, (sent + 1 == v.beats));
      if (hold) begin
        chk("stall_bits", data_o_bits, pb);
        chk("stall_strb", data_o_strb, ps);
        chk("stall_last", data_o_last, pl);
      end
      hold = vld & ~rdy;
      pb = data_o_bits;
      ps = data_o_strb;
      pl = data_o_last;
      @(negedge clk);
      if (rdy && vld) sent++;
      cyc++;
    end
    chk("beat_timeout", (cyc < 200), 1'b1);
    csr_abort_i  = 1'b0;
    csr_start_i  = 1'b0;
    data_o_ready = 1'b1;
    #1;
    chk("done_pulse", done_o, 1'b1);
    chk("done_busy", busy_o, 1'b1);
    chk("done_valid", data_o_valid, 1'b0);
    chk("beats_sent", beats_sent_o, 32'(v.beats));
    @(negedge clk);
    #1;
    chk("idle_done", done_o, 1'b0);
    chk("idle_busy", busy_o, 1'b0);
    chk("idle_valid", data_o_valid, 1'b0);
    chk("idle_sent_hold", beats_sent_o, 32'(v.beats));
  endtask

  initial begin
    vecs[0] = '{len: 32'd256, value: 32'h1234_56A5, rmode: 1'b0, abort_at: 0, beats: 4, last_strb: 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1] = '{len: 32'd130, value: 32'h0000_003C, rmode: 1'b0, abort_at: 0, beats: 3, last_strb: 64'h0000_0000_0000_0003};
    vecs[2] = '{len: 32'd64,  value: 32'hFFFF_FF5A, rmode: 1'b0, abort_at: 0, beats: 1, last_strb: 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[3] = '{len: 32'd0,   value: 32'h0000_00FF, rmode: 1'b0, abort_at: 0, beats: 0, last_strb: 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{len: 32'd512, value: 32'h0000_0077, rmode: 1'b1, abort_at: 0, beats: 8, last_strb: 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5] = '{len: 32'd640, value: 32'h0000_00C3, rmode: 1'b0, abort_at: 3, beats: 4, last_strb: 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{len: 32'd1,   value: 32'h0000_0001, rmode: 1'b0, abort_at: 0, beats: 1, last_strb: 64'h0000_0000_0000_0001};
    vecs[7] = '{len: 32'd63,  value: 32'h0000_00E7, rmode: 1'b0, abort_at: 0, beats: 1, last_strb: 64'h7FFF_FFFF_FFFF_FFFF};

    // Reset values while rst_n is held low.
    #12;
    chk("rst_valid", data_o_valid, 1'b0);
    chk("rst_last", data_o_last, 1'b0);
    chk("rst_strb", data_o_strb, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_bits", data_o_bits, 512'h0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_sent", beats_sent_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Reset dropped during the second beat of a 256-byte transfer.
    @(negedge clk);
    csr_len_i    = 32'd256;
    csr_value_i  = 32'h0000_0099;
    csr_start_i  = 1'b1;
    data_o_ready = 1'b1;
    @(negedge clk);
    csr_start_i = 1'b0;
    #1;
    chk("mid_beat1_valid", data_o_valid, 1'b1);
    @(negedge clk);
    #1;
    chk("mid_beat2_valid", data_o_valid, 1'b1);
    chk("mid_beat2_sent", beats_sent_o, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", data_o_valid, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_last", data_o_last, 1'b0);
    chk("mid_rst_bits", data_o_bits, 512'h0);
    chk("mid_rst_sent", beats_sent_o, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("mid_rst_no_done", done_o, 1'b0);
    end
    rst_n = 1'b1;
    run_vec(vecs[2]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
